// File: rtl/cci_test_csr_bank_if.sv
// Bundles the MMIO request stream from the FIU, the pass-through AFU read
// responses and the merged read response back toward the FIU.
//   master : the environment (FIU request side + AFU response side)
//   slave  : cci_test_csr_bank
//
//   mmio_req_valid/is_rd/addr/tid/wdata : MMIO request (addr is a DWORD address)
//   afu_rsp_valid/tid/data              : AFU read response for non-local reads
//   rsp_valid/tid/data                  : merged read response toward the FIU
interface cci_test_csr_bank_if;
    logic        mmio_req_valid;
    logic        mmio_req_is_rd;
    logic [15:0] mmio_req_addr;
    logic [8:0]  mmio_req_tid;
    logic [63:0] mmio_req_wdata;

    logic        afu_rsp_valid;
    logic [8:0]  afu_rsp_tid;
    logic [63:0] afu_rsp_data;

    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;

    modport master (
        output mmio_req_valid, mmio_req_is_rd, mmio_req_addr, mmio_req_tid, mmio_req_wdata,
        output afu_rsp_valid, afu_rsp_tid, afu_rsp_data,
        input  rsp_valid, rsp_tid, rsp_data
    );

    modport slave (
        input  mmio_req_valid, mmio_req_is_rd, mmio_req_addr, mmio_req_tid, mmio_req_wdata,
        input  afu_rsp_valid, afu_rsp_tid, afu_rsp_data,
        output rsp_valid, rsp_tid, rsp_data
    );
endinterface

// File: rtl/cci_test_csr_bank.sv
// MMIO CSR manager for test AFUs. Decodes 64-bit CSR accesses in the local
// window [0, CSR_BASE+NUM_CSRS), drives one-hot write strobes to user CSRs,
// keeps a bank of saturating event counters with snapshot/clear through the
// CTRL register at index 0, and merges locally generated read responses
// (buffered in a FIFO) with pass-through AFU read responses.
//
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   bus           : MMIO request / AFU response / merged response (slave)
//   csr_rd_data   : user CSR read values, 64 bits per CSR
//   csr_wr_en     : one-hot user CSR write strobe (one cycle)
//   csr_wr_data   : user CSR write data
//   ctr_inc       : per-counter increment events
//   err_overflow  : sticky, set when a local read response had to be dropped
//
// Index map: 0 = CTRL/status, 1..NUM_COUNTERS = counter snapshots,
// CSR_BASE.. = user CSRs, everything else below the window end reads 0.
module cci_test_csr_bank #(
    parameter int NUM_CSRS       = 16,
    parameter int CSR_BASE       = 32,
    parameter int NUM_COUNTERS   = 8,
    parameter int COUNTER_WIDTH  = 48,
    parameter int RSP_FIFO_DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    cci_test_csr_bank_if.slave       bus,
    input  logic [NUM_CSRS*64-1:0]   csr_rd_data,
    output logic [NUM_CSRS-1:0]      csr_wr_en,
    output logic [63:0]              csr_wr_data,
    input  logic [NUM_COUNTERS-1:0]  ctr_inc,
    output logic                     err_overflow
);
    localparam int AW        = $clog2(RSP_FIFO_DEPTH);
    localparam int LOCAL_END = CSR_BASE + NUM_CSRS;
    localparam logic [COUNTER_WIDTH-1:0] CTR_MAX = {COUNTER_WIDTH{1'b1}};
    localparam logic [COUNTER_WIDTH-1:0] CTR_ONE = COUNTER_WIDTH'(1);
    localparam logic [AW:0]              PTR_ONE = (AW+1)'(1);

    // Reset is asserted asynchronously but released on a clock edge so all
    // internal flops leave reset in the same cycle.
    logic rst_meta_q, rst_sync_q, rst_n_int;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end
    assign rst_n_int = rst_sync_q;

    logic unused_addr_lsb;
    assign unused_addr_lsb = bus.mmio_req_addr[0];

    // ---------------- request register (edge N) ----------------
    logic        req_vld_q, req_vld_d;
    logic        req_rd_q, req_rd_d;
    logic [14:0] req_idx_q, req_idx_d;
    logic [8:0]  req_tid_q, req_tid_d;
    logic [63:0] req_wdata_q, req_wdata_d;
    logic        req_local;

    assign req_local = ({17'b0, bus.mmio_req_addr[15:1]} < 32'(LOCAL_END));

    always_comb begin
        req_vld_d   = bus.mmio_req_valid & req_local;
        req_rd_d    = req_rd_q;
        req_idx_d   = req_idx_q;
        req_tid_d   = req_tid_q;
        req_wdata_d = req_wdata_q;
        if (bus.mmio_req_valid && req_local) begin
            req_rd_d    = bus.mmio_req_is_rd;
            req_idx_d   = bus.mmio_req_addr[15:1];
            req_tid_d   = bus.mmio_req_tid;
            req_wdata_d = bus.mmio_req_wdata;
        end
    end

    // ---------------- decode and read mux (cycle N+1) ----------------
    logic [NUM_CSRS-1:0]      user_hit;
    logic [63:0]              rd_data;
    logic                     err_q, err_d;
    logic [COUNTER_WIDTH-1:0] ctr_q  [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] ctr_d  [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] snap_q [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] snap_d [NUM_COUNTERS];

    always_comb begin
        user_hit = '0;
        rd_data  = '0;
        if (req_idx_q == 15'd0) begin
            rd_data = {err_q, 47'b0, 16'(NUM_COUNTERS)};
        end
        for (int k = 0; k < NUM_COUNTERS; k++) begin
            if ({17'b0, req_idx_q} == 32'(k + 1)) begin
                rd_data = 64'(snap_q[k]);
            end
        end
        for (int i = 0; i < NUM_CSRS; i++) begin
            if ({17'b0, req_idx_q} == 32'(CSR_BASE + i)) begin
                user_hit[i] = 1'b1;
                rd_data     = csr_rd_data[i*64 +: 64];
            end
        end
    end

    logic is_wr, ctrl_wr, ctrl_snap, ctrl_clr;

    assign is_wr     = req_vld_q & ~req_rd_q;
    assign ctrl_wr   = is_wr & (req_idx_q == 15'd0);
    assign ctrl_snap = ctrl_wr & req_wdata_q[0];
    assign ctrl_clr  = ctrl_wr & req_wdata_q[1];

    // ---------------- user CSR write strobe ----------------
    logic [NUM_CSRS-1:0] csr_wr_en_q, csr_wr_en_d;
    logic [63:0]         csr_wr_data_q, csr_wr_data_d;

    always_comb begin
        csr_wr_en_d   = is_wr ? user_hit : '0;
        csr_wr_data_d = (is_wr && (|user_hit)) ? req_wdata_q : csr_wr_data_q;
    end

    assign csr_wr_en   = csr_wr_en_q;
    assign csr_wr_data = csr_wr_data_q;

    // ---------------- event counters ----------------
    // Snapshot takes the value before this edge, so it sees the pre-clear
    // count and excludes any same-cycle increment; clear wins over increment.
    always_comb begin
        for (int k = 0; k < NUM_COUNTERS; k++) begin
            snap_d[k] = ctrl_snap ? ctr_q[k] : snap_q[k];
            if (ctrl_clr) begin
                ctr_d[k] = '0;
            end else if (ctr_inc[k] && (ctr_q[k] != CTR_MAX)) begin
                ctr_d[k] = ctr_q[k] + CTR_ONE;
            end else begin
                ctr_d[k] = ctr_q[k];
            end
        end
    end

    // ---------------- local response FIFO ----------------
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [72:0] fifo_mem [RSP_FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        fifo_empty, fifo_full, push, pop, push_ok;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign push       = req_vld_q & req_rd_q;
    assign pop        = ~bus.afu_rsp_valid & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok    = push & (~fifo_full | pop);

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        err_d    = err_q | (push & ~push_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {req_tid_q, rd_data};
        end
    end

    assign err_overflow = err_q;

    // ---------------- response merge ----------------
    logic        rsp_vld_q, rsp_vld_d;
    logic [8:0]  rsp_tid_q, rsp_tid_d;
    logic [63:0] rsp_data_q, rsp_data_d;

    always_comb begin
        rsp_vld_d  = 1'b0;
        rsp_tid_d  = rsp_tid_q;
        rsp_data_d = rsp_data_q;
        if (bus.afu_rsp_valid) begin
            rsp_vld_d  = 1'b1;
            rsp_tid_d  = bus.afu_rsp_tid;
            rsp_data_d = bus.afu_rsp_data;
        end else if (pop) begin
            rsp_vld_d               = 1'b1;
            {rsp_tid_d, rsp_data_d} = fifo_mem[rd_ptr_q[AW-1:0]];
        end
    end

    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_tid   = rsp_tid_q;
    assign bus.rsp_data  = rsp_data_q;

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            req_vld_q     <= 1'b0;
            req_rd_q      <= 1'b0;
            req_idx_q     <= '0;
            req_tid_q     <= '0;
            req_wdata_q   <= '0;
            csr_wr_en_q   <= '0;
            csr_wr_data_q <= '0;
            err_q         <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rsp_vld_q     <= 1'b0;
            rsp_tid_q     <= '0;
            rsp_data_q    <= '0;
            for (int k = 0; k < NUM_COUNTERS; k++) begin
                ctr_q[k]  <= '0;
                snap_q[k] <= '0;
            end
        end else begin
            req_vld_q     <= req_vld_d;
            req_rd_q      <= req_rd_d;
            req_idx_q     <= req_idx_d;
            req_tid_q     <= req_tid_d;
            req_wdata_q   <= req_wdata_d;
            csr_wr_en_q   <= csr_wr_en_d;
            csr_wr_data_q <= csr_wr_data_d;
            err_q         <= err_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rsp_vld_q     <= rsp_vld_d;
            rsp_tid_q     <= rsp_tid_d;
            rsp_data_q    <= rsp_data_d;
            for (int k = 0; k < NUM_COUNTERS; k++) begin
                ctr_q[k]  <= ctr_d[k];
                snap_q[k] <= snap_d[k];
            end
        end
    end
endmodule

// File: tb/tb_cci_test_csr_bank.sv
// Bench for cci_test_csr_bank: directed scenarios followed by random traffic,
// with every cycle compared against a transaction-level reference model.
// Built with a 4-bit counter and a 4-entry response FIFO so saturation and
// overflow are reachable quickly.
module tb_cci_test_csr_bank;
    localparam int NCSR  = 16;
    localparam int BASE  = 32;
    localparam int NCTR  = 8;
    localparam int CW    = 4;
    localparam int DEPTH = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    cci_test_csr_bank_if bus();
    logic [NCSR*64-1:0] csr_rd_data;
    logic [NCSR-1:0]    csr_wr_en;
    logic [63:0]        csr_wr_data;
    logic [NCTR-1:0]    ctr_inc;
    logic               err_overflow;

    cci_test_csr_bank #(
        .NUM_CSRS      (NCSR),
        .CSR_BASE      (BASE),
        .NUM_COUNTERS  (NCTR),
        .COUNTER_WIDTH (CW),
        .RSP_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .csr_rd_data (csr_rd_data),
        .csr_wr_en   (csr_wr_en),
        .csr_wr_data (csr_wr_data),
        .ctr_inc     (ctr_inc),
        .err_overflow(err_overflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int unsigned     m_live [NCTR];
    int unsigned     m_snap [NCTR];
    logic            m_err;
    logic [72:0]     m_fifo [$];
    logic            p_valid, p_rd;
    int              p_idx;
    logic [8:0]      p_tid;
    logic [63:0]     p_wdata;
    logic            e_rsp_valid;
    logic [8:0]      e_rsp_tid;
    logic [63:0]     e_rsp_data;
    logic [NCSR-1:0] e_wr_en;
    logic [63:0]     e_wr_data;
    logic [8:0]      obs_tid [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_rd_data(input int idx);
        if (idx == 0) return {m_err, 47'b0, 16'(NCTR)};
        if (idx >= 1 && idx <= NCTR) return 64'(m_snap[idx-1]);
        if (idx >= BASE && idx < BASE + NCSR) return csr_rd_data[(idx-BASE)*64 +: 64];
        return 64'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCTR; k++) begin
            m_live[k] = 0;
            m_snap[k] = 0;
        end
        m_err = 1'b0;
        m_fifo.delete();
        p_valid     = 1'b0;
        p_rd        = 1'b0;
        p_idx       = 0;
        p_tid       = '0;
        p_wdata     = '0;
        e_rsp_valid = 1'b0;
        e_rsp_tid   = '0;
        e_rsp_data  = '0;
        e_wr_en     = '0;
        e_wr_data   = '0;
    endtask

    // Effect of one clock edge, given the inputs present at that edge.
    task automatic model_edge();
        logic [72:0] ent;
        logic [63:0] d;
        bit snap, clr;
        snap = 0;
        clr  = 0;
        if (bus.afu_rsp_valid) begin
            e_rsp_valid = 1'b1;
            e_rsp_tid   = bus.afu_rsp_tid;
            e_rsp_data  = bus.afu_rsp_data;
        end else if (m_fifo.size() > 0) begin
            ent = m_fifo.pop_front();
            e_rsp_valid = 1'b1;
            {e_rsp_tid, e_rsp_data} = ent;
        end else begin
            e_rsp_valid = 1'b0;
        end
        e_wr_en = '0;
        if (p_valid) begin
            if (p_rd) begin
                d = model_rd_data(p_idx);
                if (m_fifo.size() < DEPTH) m_fifo.push_back({p_tid, d});
                else m_err = 1'b1;
            end else if (p_idx == 0) begin
                snap = p_wdata[0];
                clr  = p_wdata[1];
            end else if (p_idx >= BASE) begin
                e_wr_en   = NCSR'(1) << (p_idx - BASE);
                e_wr_data = p_wdata;
            end
        end
        for (int k = 0; k < NCTR; k++) begin
            if (snap) m_snap[k] = m_live[k];
            if (clr) m_live[k] = 0;
            else if (ctr_inc[k] && m_live[k] < CMAX) m_live[k] = m_live[k] + 1;
        end
        p_idx   = int'(bus.mmio_req_addr[15:1]);
        p_valid = bus.mmio_req_valid && (p_idx < BASE + NCSR);
        p_rd    = bus.mmio_req_is_rd;
        p_tid   = bus.mmio_req_tid;
        p_wdata = bus.mmio_req_wdata;
    endtask

    task automatic compare();
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(e_rsp_valid));
        if (e_rsp_valid) begin
            chk("rsp_tid", 64'(bus.rsp_tid), 64'(e_rsp_tid));
            chk("rsp_data", bus.rsp_data, e_rsp_data);
        end
        chk("csr_wr_en", 64'(csr_wr_en), 64'(e_wr_en));
        if (e_wr_en != '0) chk("csr_wr_data", csr_wr_data, e_wr_data);
        chk("err_overflow", 64'(err_overflow), 64'(m_err));
        if (bus.rsp_valid) obs_tid.push_back(bus.rsp_tid);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle();
        bus.mmio_req_valid = 1'b0;
        bus.mmio_req_is_rd = 1'b0;
        bus.mmio_req_addr  = '0;
        bus.mmio_req_tid   = '0;
        bus.mmio_req_wdata = '0;
        bus.afu_rsp_valid  = 1'b0;
        bus.afu_rsp_tid    = '0;
        bus.afu_rsp_data   = '0;
        ctr_inc            = '0;
    endtask

    task automatic issue(input logic rd, input logic [15:0] addr, input logic [8:0] tid,
                         input logic [63:0] wdata);
        bus.mmio_req_valid = 1'b1;
        bus.mmio_req_is_rd = rd;
        bus.mmio_req_addr  = addr;
        bus.mmio_req_tid   = tid;
        bus.mmio_req_wdata = wdata;
        step();
        bus.mmio_req_valid = 1'b0;
    endtask

    task automatic rd_expect(input string tag, input logic [15:0] addr, input logic [8:0] tid,
                             input logic [63:0] exp);
        bit seen;
        seen = 0;
        issue(1'b1, addr, tid, 64'd0);
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            if (bus.rsp_valid && bus.rsp_tid == tid) begin
                seen = 1;
                chk(tag, bus.rsp_data, exp);
            end
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        #1;
        model_reset();
        compare();
        repeat (3) step();
        reset_n = 1'b1;
        repeat (4) step();
        chk("rst_err", 64'(err_overflow), 64'd0);
    endtask

    initial begin
        idle();
        for (int i = 0; i < NCSR; i++) csr_rd_data[i*64 +: 64] = {$urandom, $urandom};
        model_reset();
        #2;
        do_reset();

        // User CSR write: strobe bit 3 for exactly one cycle
        issue(1'b0, 16'd70, 9'd0, 64'hDEAD_BEEF_0000_0001);
        step();
        chk("t1_wr_en", 64'(csr_wr_en), 64'h8);
        chk("t1_wr_data", csr_wr_data, 64'hDEAD_BEEF_0000_0001);
        chk("t1_no_rsp", 64'(bus.rsp_valid), 64'd0);
        step();
        chk("t1_wr_en_off", 64'(csr_wr_en), 64'd0);

        // User CSR read: response in cycle N+2
        csr_rd_data[3*64 +: 64] = 64'h1234;
        issue(1'b1, 16'd70, 9'h15, 64'd0);
        step();
        step();
        chk("t2_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t2_tid", 64'(bus.rsp_tid), 64'h15);
        chk("t2_data", bus.rsp_data, 64'h1234);
        repeat (2) step();

        // Snapshot + clear, then snapshot only
        for (int i = 0; i < 5; i++) begin
            ctr_inc = 8'b0000_0100; step();
            ctr_inc = '0;           step();
        end
        issue(1'b0, 16'd0, 9'd0, 64'h3);
        step();
        for (int i = 0; i < 2; i++) begin
            ctr_inc = 8'b0000_0100; step();
            ctr_inc = '0;           step();
        end
        rd_expect("t3_snap5", 16'd6, 9'h21, 64'd5);
        issue(1'b0, 16'd0, 9'd0, 64'h1);
        step();
        rd_expect("t3_snap2", 16'd6, 9'h22, 64'd2);

        // Saturation at 2^CW-1
        ctr_inc = 8'b0000_0001;
        repeat (20) step();
        ctr_inc = '0;
        issue(1'b0, 16'd0, 9'd0, 64'h1);
        step();
        rd_expect("t4_sat", 16'd2, 9'h23, 64'(CMAX));
        repeat (3) step();

        // AFU responses have priority; local reads wait without loss
        obs_tid.delete();
        for (int i = 0; i < 16; i++) begin
            bus.afu_rsp_valid  = (i < 10);
            bus.afu_rsp_tid    = 9'(256 + i);
            bus.afu_rsp_data   = {$urandom, $urandom};
            bus.mmio_req_valid = (i < 3);
            bus.mmio_req_is_rd = 1'b1;
            bus.mmio_req_addr  = 16'(2 * (BASE + i));
            bus.mmio_req_tid   = 9'(i + 1);
            step();
        end
        idle();
        repeat (2) step();
        chk("t5_count", 64'(obs_tid.size()), 64'd13);
        for (int i = 0; i < 13 && i < obs_tid.size(); i++)
            chk("t5_order", 64'(obs_tid[i]), (i < 10) ? 64'(256 + i) : 64'(i - 9));
        chk("t5_err", 64'(err_overflow), 64'd0);

        // Overflow: FIFO of DEPTH fills behind AFU stream, next read dropped
        obs_tid.delete();
        for (int i = 0; i < 14; i++) begin
            bus.afu_rsp_valid  = (i < 10);
            bus.afu_rsp_tid    = 9'(384 + i);
            bus.afu_rsp_data   = {$urandom, $urandom};
            bus.mmio_req_valid = (i < DEPTH + 1);
            bus.mmio_req_is_rd = 1'b1;
            bus.mmio_req_addr  = 16'(2 * (BASE + 1));
            bus.mmio_req_tid   = 9'(i + 1);
            step();
        end
        idle();
        repeat (2) step();
        chk("t6_count", 64'(obs_tid.size()), 64'(10 + DEPTH));
        for (int i = 10; i < 10 + DEPTH && i < obs_tid.size(); i++)
            chk("t6_kept", 64'(obs_tid[i]), 64'(i - 9));
        chk("t6_err", 64'(err_overflow), 64'd1);
        rd_expect("t6_ctrl", 16'd0, 9'h1f, 64'h8000_0000_0000_0008);

        // Reset with pending FIFO entries and an in-flight write strobe
        bus.afu_rsp_valid = 1'b1;
        for (int i = 0; i < 2; i++) issue(1'b1, 16'(2 * BASE), 9'(i + 40), 64'd0);
        issue(1'b0, 16'(2 * (BASE + 5)), 9'd0, 64'h55);
        obs_tid.delete();
        do_reset();
        chk("t6_fifo_empty", 64'(obs_tid.size()), 64'd0);

        // Random traffic against the model, with one reset in the middle
        for (int c = 0; c < 600; c++) begin
            int idx;
            case ($urandom_range(0, 4))
                0:       idx = 0;
                1:       idx = $urandom_range(1, NCTR);
                2:       idx = $urandom_range(NCTR + 1, BASE - 1);
                3:       idx = $urandom_range(BASE, BASE + NCSR - 1);
                default: idx = $urandom_range(BASE + NCSR, 32767);
            endcase
            bus.mmio_req_valid = ($urandom_range(0, 9) < 5);
            bus.mmio_req_is_rd = 1'($urandom_range(0, 1));
            bus.mmio_req_addr  = 16'((idx << 1) | $urandom_range(0, 1));
            bus.mmio_req_tid   = 9'($urandom);
            bus.mmio_req_wdata = {$urandom, $urandom};
            bus.afu_rsp_valid  = ($urandom_range(0, 3) == 0);
            bus.afu_rsp_tid    = 9'($urandom);
            bus.afu_rsp_data   = {$urandom, $urandom};
            ctr_inc            = 8'($urandom);
            if (c % 100 == 0)
                for (int i = 0; i < NCSR; i++) csr_rd_data[i*64 +: 64] = {$urandom, $urandom};
            if (c == 300) do_reset();
            else step();
        end
        idle();
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
